sweep_collector: RTL
====================

# sweep_collector

Collects completed sweep measurements from up to 16 per-photodiode lighthouse decoders and queues them, tagged with sensor index, in a first-word-fall-through FIFO for the Avalon readout logic. It replaces polling of 16 separate value registers with one ordered event stream, so the host never misses or double-reads a sweep. It sits between the decoder array (upstream) and the Avalon slave register map (downstream). All logic runs on the system clock; decoder handshake inputs are synchronised internally.

## Interface
- NUM_SENSORS, 16, number of decoder channels (1..16); index width fixed at 4 bits
- FIFO_DEPTH, 64, entry count; power of two, 4..256
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- sensor_value_i  in  32*NUM_SENSORS  decoder results, channel k in bits [32k+31:32k]
- data_available_i  in  NUM_SENSORS  per-channel valid level from decoders, asynchronous to clock
- rd_data  out  32  value of FIFO head entry
- rd_id  out  4  sensor index of FIFO head entry
- rd_valid  out  1  FIFO non-empty; rd_data/rd_id are meaningful
- rd_pop  in  1  consume head entry this cycle; ignored when rd_valid=0
- fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  sticky: at least one measurement dropped since last clear
- drop_count  out  16  dropped measurements, saturates at 16'hFFFF
- clear_i  in  1  clears overflow and drop_count

## Operation
- Synchroniser: per channel, 3-flop chain s1->s2->s3; all reset to 0. Edge event on channel k when s2=1 and s3=0.
- Capture: on edge event, sensor_value_i[k] (required stable from data_available_i rise until ≥3 clocks after) is latched into pending_val[k], pending[k] set.
- Drop: edge event while pending[k] already set and not granted this cycle -> pending_val[k] overwritten with newer value, drop_count+1 (saturating), overflow set.
- Arbiter: round-robin over pending[], one grant per cycle, only when FIFO not full or rd_pop accepted same cycle. Grant = lowest pending index ≥ rr_ptr, wrapping; rr_ptr := grant+1 mod NUM_SENSORS. rr_ptr resets to 0; unchanged when no grant.
- Push: granted entry {id, pending_val} written to FIFO, pending[grant] cleared — unless a new edge event on the same channel in that cycle, in which case old value is pushed and new value becomes pending (no drop).
- FIFO full: pending entries wait; further edges on waiting channels count as drops.
- Pop on empty: no effect. Push and pop same cycle: count unchanged, both performed (including when full).
- clear_i: overflow<=0, drop_count<=0; if a drop occurs same cycle, result is overflow=1, drop_count=1.
- A data_available_i level already high at reset release produces exactly one capture.

## Timing
- Reset values: rd_valid=0, rd_data=0, rd_id=0, fifo_count=0, overflow=0, drop_count=0; FIFO pointers, pending[], rr_ptr cleared.
- Latency: data_available_i first sampled high at edge E0 -> s2 high after E1 -> capture at E2 -> push at E3 -> rd_valid=1 after E3 (4 edges).
- rd_data/rd_id/rd_valid are registered-flag FWFT: valid in the cycle after the push; after a pop the next entry appears the cycle following the pop edge.
- fifo_count updates on the same edge as push/pop.
- Throughput: one push and one pop per cycle sustained.
- Pointers wrap modulo FIFO_DEPTH; full = count==FIFO_DEPTH, empty = count==0.

## Test plan
- Single event: channel 5 value 32'h0001_2345, data_available pulse 5 clocks -> after 4 edges rd_valid=1, rd_id=5, rd_data=32'h0001_2345, fifo_count=1; rd_pop -> rd_valid=0.
- Simultaneous: channels 0,3,15 rise same cycle, rr_ptr=0 -> FIFO order ids 0,3,15 on consecutive cycles; next simultaneous 0 and 15 -> order 0,15 (rr_ptr=4 after 3? no: after 15 rr_ptr=0 -> 0 first).
- Full: 64 events with no pops -> fifo_count=64; 65th on channel 2 held pending; second edge on channel 2 -> drop_count=1, overflow=1; one pop -> newest channel-2 value enters, fifo_count=64.
- Push+pop at full: full FIFO, rd_pop with pending entry -> fifo_count stays 64, order preserved.
- Clear/drop collision and saturation: clear_i same cycle as drop -> drop_count=1; force 70000 drops -> drop_count=16'hFFFF.
- Reset mid-stream: assert reset with 10 entries and 3 pending -> all outputs 0 immediately (async); data_available held high through release -> exactly one entry per high channel.

Source files
------------

// File: rtl/sweep_collector_if.sv
// Readout-side bundle of sweep_collector: FWFT head, pop strobe and
// drop/overflow status toward the Avalon register map.
interface sweep_collector_if #(
    parameter int FIFO_DEPTH = 64
);
    logic [31:0]                   rd_data;
    logic [3:0]                    rd_id;
    logic                          rd_valid;
    logic                          rd_pop;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;
    logic [15:0]                   drop_count;
    logic                          clear_i;

    modport master (
        output rd_data, rd_id, rd_valid,
        output fifo_count, overflow, drop_count,
        input  rd_pop, clear_i
    );

    modport slave (
        input  rd_data, rd_id, rd_valid,
        input  fifo_count, overflow, drop_count,
        output rd_pop, clear_i
    );
endinterface

// File: rtl/sweep_collector.sv
// Synchronises per-sensor decoder valids, captures completed sweeps and
// queues them tagged with sensor index in a first-word-fall-through FIFO.
module sweep_collector #(
    parameter int NUM_SENSORS = 16,
    parameter int FIFO_DEPTH  = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [32*NUM_SENSORS-1:0] sensor_value_i,
    input  logic [NUM_SENSORS-1:0]    data_available_i,
    sweep_collector_if.master         rd_if
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [NUM_SENSORS-1:0] s1_q, s2_q, s3_q;
    logic [NUM_SENSORS-1:0] pending_q, pending_d;
    logic [31:0]            pending_val_q [NUM_SENSORS];
    logic [31:0]            pending_val_d [NUM_SENSORS];
    logic [3:0]             rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [15:0]            drop_count_q, drop_count_d;
    logic [35:0]            mem_q [FIFO_DEPTH];

    logic [NUM_SENSORS-1:0] edge_ev;
    logic                   head_valid;
    logic                   pop;
    logic                   can_push;
    logic                   gnt_valid;
    logic [3:0]             gnt_idx;
    logic [4:0]             cand;
    logic [4:0]             n_drop;
    logic [16:0]            drop_sum;

    assign edge_ev    = s2_q & ~s3_q;
    assign head_valid = (count_q != '0);
    assign pop        = rd_if.rd_pop && head_valid;
    assign can_push   = (count_q != CW'(FIFO_DEPTH)) || pop;

    // Round-robin search starting at rr_ptr, wrapping at NUM_SENSORS.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            cand = {1'b0, rr_ptr_q} + 5'(i);
            if (cand >= 5'(NUM_SENSORS)) begin
                cand = cand - 5'(NUM_SENSORS);
            end
            if (!gnt_valid && can_push && pending_q[cand[3:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[3:0];
            end
        end
    end

    // A granted slot is freed first, so a same-cycle edge refills it
    // without counting as a drop.
    always_comb begin
        pending_d     = pending_q;
        pending_val_d = pending_val_q;
        n_drop        = '0;
        for (int k = 0; k < NUM_SENSORS; k++) begin
            if (gnt_valid && (gnt_idx == 4'(k))) begin
                pending_d[k] = 1'b0;
            end
            if (edge_ev[k]) begin
                if (pending_d[k]) begin
                    n_drop = n_drop + 5'd1;
                end
                pending_d[k]     = 1'b1;
                pending_val_d[k] = sensor_value_i[32*k +: 32];
            end
        end
    end

    always_comb begin
        drop_sum = {1'b0, (rd_if.clear_i ? 16'd0 : drop_count_q)}
                 + {12'd0, n_drop};
        drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        overflow_d   = (overflow_q && !rd_if.clear_i) || (n_drop != '0);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(gnt_valid);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(gnt_valid) - CW'(pop);
        rr_ptr_d = rr_ptr_q;
        if (gnt_valid) begin
            rr_ptr_d = (gnt_idx == 4'(NUM_SENSORS - 1)) ? 4'd0
                                                        : gnt_idx + 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q         <= '0;
            s2_q         <= '0;
            s3_q         <= '0;
            pending_q    <= '0;
            rr_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            for (int k = 0; k < NUM_SENSORS; k++) begin
                pending_val_q[k] <= '0;
            end
        end else begin
            s1_q         <= data_available_i;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            pending_q    <= pending_d;
            rr_ptr_q     <= rr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            for (int k = 0; k < NUM_SENSORS; k++) begin
                pending_val_q[k] <= pending_val_d[k];
            end
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (gnt_valid) begin
            mem_q[wr_ptr_q] <= {gnt_idx, pending_val_q[gnt_idx]};
        end
    end

    assign rd_if.rd_valid   = head_valid;
    assign {rd_if.rd_id, rd_if.rd_data} =
        head_valid ? mem_q[rd_ptr_q] : 36'd0;
    assign rd_if.fifo_count = count_q;
    assign rd_if.overflow   = overflow_q;
    assign rd_if.drop_count = drop_count_q;
endmodule
